// File: rtl/sd_dat_pkg.sv
// -----------------------------------------------------------------------------
// sd_dat_pkg
// Shared definitions for the SD DAT transfer sequencer:
//   - state_t      : 3-bit sequencer state encoding
//   - ERR_*        : error code values reported on err_code_o
//   - DEF_*        : default block-count width, per-block timeout, timer width
//   - fifo_ready() : direction-aware FIFO readiness test
// -----------------------------------------------------------------------------
package sd_dat_pkg;

  localparam int DEF_BLK_W          = 11;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_TMR_W          = 13;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FIFO = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_XFER      = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERR       = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_CRC     = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  // A write drains the FIFO toward the card, so it needs data present.
  // A read fills the FIFO from the card, so it needs room available.
  function automatic logic fifo_ready(input logic dir_read,
                                      input logic fifo_full,
                                      input logic fifo_empty);
    return dir_read ? !fifo_full : !fifo_empty;
  endfunction

endpackage

// File: rtl/sd_dat_timeout_timer.sv
// -----------------------------------------------------------------------------
// sd_dat_timeout_timer
// Per-block watchdog. Counts cycles while enabled; expired_o is high once the
// count reaches TIMEOUT_CYCLES-1, and the count then holds there.
// TMR_W must satisfy 2**TMR_W > TIMEOUT_CYCLES.
// Ports:
//   clock      in  system clock, rising edge
//   reset      in  asynchronous active-low reset
//   clear_i    in  synchronous clear (wins over enable_i)
//   enable_i   in  count enable
//   expired_o  out count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module sd_dat_timeout_timer
  import sd_dat_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TMR_W          = DEF_TMR_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TMR_W-1:0] LAST_CNT = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_count;

  assign expired_o = (r_count == LAST_CNT);

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (enable_i && !expired_o) begin
      r_count <= r_count + TMR_W'(1);
    end
  end

endmodule

// File: rtl/sd_dat_sequencer.sv
// -----------------------------------------------------------------------------
// sd_dat_sequencer
// Sequences a multi-block SD data transfer through the DAT module: latches the
// request, waits for FIFO readiness before each block, pulses new_trans_o once
// per block, counts completed blocks and reports done / error status.
// Optional build macro: SD_DAT_AUTO_STOP_EN adds stop_req_o (CMD12 request).
// Ports:
//   clock, reset         system clock; asynchronous active-low reset
//   start_i              one-cycle request, ignored while busy
//   block_amount_i       block count (0 finishes immediately)
//   direction_i/mode_i   0 write / 1 read; 0 1-bit / 1 4-bit bus
//   abort_i              software abort, level
//   fifo_full_i/empty_i  FIFO status used to gate each block
//   dat_done_i           DAT finished current block; dat_crc_err_i qualifies it
//   new_trans_o          one-cycle block launch to DAT
//   dat_direction_o/dat_mode_o  latched transfer settings to DAT
//   busy_o, done_o       in progress; one-cycle completion pulse
//   error_o, err_code_o  sticky error flag and cause (ERR_* codes)
//   blocks_left_o        remaining blocks
//   stop_req_o           (SD_DAT_AUTO_STOP_EN only) one-cycle CMD12 request
// -----------------------------------------------------------------------------
module sd_dat_sequencer
  import sd_dat_pkg::*;
#(
  parameter int BLK_W          = DEF_BLK_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TMR_W          = DEF_TMR_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [BLK_W-1:0] block_amount_i,
  input  logic             direction_i,
  input  logic             mode_i,
  input  logic             abort_i,
  input  logic             fifo_full_i,
  input  logic             fifo_empty_i,
  input  logic             dat_done_i,
  input  logic             dat_crc_err_i,
  output logic             new_trans_o,
  output logic             dat_direction_o,
  output logic             dat_mode_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [1:0]       err_code_o,
  output logic [BLK_W-1:0] blocks_left_o
`ifdef SD_DAT_AUTO_STOP_EN
  ,
  output logic             stop_req_o
`endif
);

  state_t     r_state;
  logic [1:0] r_err_code;   // cause captured on entry to ST_ERR
  logic       w_expired;
  logic       w_fifo_ready;
  logic       w_abort;

`ifdef SD_DAT_AUTO_STOP_EN
  logic r_multi_block;      // latched block count was > 1
  logic r_launched;         // at least one block was launched
`endif

  assign w_fifo_ready = fifo_ready(dat_direction_o, fifo_full_i, fifo_empty_i);
  // ST_ERR is already heading to IDLE; re-entering it would only loop.
  assign w_abort      = abort_i && (r_state != ST_IDLE) && (r_state != ST_ERR);

  sd_dat_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (r_state == ST_LAUNCH),
    .enable_i  (r_state == ST_XFER),
    .expired_o (w_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_err_code      <= ERR_NONE;
      new_trans_o     <= 1'b0;
      dat_direction_o <= 1'b0;
      dat_mode_o      <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      error_o         <= 1'b0;
      err_code_o      <= ERR_NONE;
      blocks_left_o   <= '0;
`ifdef SD_DAT_AUTO_STOP_EN
      r_multi_block   <= 1'b0;
      r_launched      <= 1'b0;
      stop_req_o      <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low each cycle; branches below raise them.
      new_trans_o <= 1'b0;
      done_o      <= 1'b0;
`ifdef SD_DAT_AUTO_STOP_EN
      stop_req_o  <= 1'b0;
`endif

      if (w_abort) begin
        // Highest priority: blocks_left_o and all other status freeze.
        r_err_code <= ERR_ABORT;
        r_state    <= ST_ERR;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start_i) begin
              dat_direction_o <= direction_i;
              dat_mode_o      <= mode_i;
              blocks_left_o   <= block_amount_i;
              error_o         <= 1'b0;
              err_code_o      <= ERR_NONE;
              busy_o          <= 1'b1;
`ifdef SD_DAT_AUTO_STOP_EN
              r_multi_block   <= (block_amount_i > BLK_W'(1));
              r_launched      <= 1'b0;
`endif
              r_state <= (block_amount_i == '0) ? ST_DONE : ST_WAIT_FIFO;
            end
          end

          ST_WAIT_FIFO: begin
            if (w_fifo_ready) begin
              new_trans_o <= 1'b1;
`ifdef SD_DAT_AUTO_STOP_EN
              r_launched  <= 1'b1;
`endif
              r_state     <= ST_LAUNCH;
            end
          end

          ST_LAUNCH: begin
            r_state <= ST_XFER;
          end

          ST_XFER: begin
            if (dat_done_i && dat_crc_err_i) begin
              r_err_code <= ERR_CRC;
              r_state    <= ST_ERR;
            end else if (dat_done_i) begin
              if (blocks_left_o != '0) begin
                blocks_left_o <= blocks_left_o - BLK_W'(1);
              end
              r_state <= (blocks_left_o <= BLK_W'(1)) ? ST_DONE : ST_WAIT_FIFO;
            end else if (w_expired) begin
              r_err_code <= ERR_TIMEOUT;
              r_state    <= ST_ERR;
            end
          end

          ST_DONE: begin
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
`ifdef SD_DAT_AUTO_STOP_EN
            stop_req_o <= r_multi_block;
`endif
            r_state    <= ST_IDLE;
          end

          ST_ERR: begin
            error_o    <= 1'b1;
            err_code_o <= r_err_code;
            busy_o     <= 1'b0;
`ifdef SD_DAT_AUTO_STOP_EN
            stop_req_o <= (r_err_code == ERR_ABORT) && r_launched;
`endif
            r_state    <= ST_IDLE;
          end

          default: begin
            busy_o  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/sd_dat_sequencer.md
Name: sd_dat_sequencer

Overview:
- Sequences multi-block SD data transfers through the DAT module.
- Latches a transfer request from the register bank: block count, direction and bus mode.
- Gates each block on FIFO readiness, pulses new_trans to DAT once per block, and counts completed blocks.
- Detects CRC error, timeout and abort; reports busy, done and error status back to the register bank.

Parameters:
- BLK_W, 11, width of block count (matches DAT block_amount).
- TIMEOUT_CYCLES, 4096, max clock cycles allowed per block between new_trans and dat_done.
- TMR_W, 13, timeout counter width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle transfer request; ignored while busy_o=1.
- block_amount_i  in  BLK_W  number of blocks, sampled on start_i.
- direction_i  in  1  0 = write (host to card), 1 = read; sampled on start_i.
- mode_i  in  1  1 = 4-bit bus, 0 = 1-bit bus; sampled on start_i.
- abort_i  in  1  software abort, level.
- fifo_full_i  in  1  FIFO full.
- fifo_empty_i  in  1  FIFO empty.
- dat_done_i  in  1  one-cycle pulse from DAT: current block finished.
- dat_crc_err_i  in  1  qualifies dat_done_i; block CRC failed.
- new_trans_o  out  1  one-cycle pulse to DAT: start one block.
- dat_direction_o  out  1  latched direction to DAT.
- dat_mode_o  out  1  latched mode to DAT.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle completion pulse.
- error_o  out  1  sticky error flag; cleared by the next accepted start_i.
- err_code_o  out  2  0 none, 1 timeout, 2 CRC, 3 abort.
- blocks_left_o  out  BLK_W  remaining block count.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0; timer 0.
- States: IDLE, WAIT_FIFO, LAUNCH, XFER, DONE, ERR.
- IDLE, start_i=1:
  - Latch direction and mode; load blocks_left_o from block_amount_i.
  - Clear error_o and err_code_o.
  - Go to WAIT_FIFO, or to DONE if block_amount_i = 0 (no new_trans_o issued).
- busy_o = 1 in every state except IDLE.
- WAIT_FIFO:
  - Write (direction 0) proceeds when fifo_empty_i=0.
  - Read (direction 1) proceeds when fifo_full_i=0.
  - Otherwise wait indefinitely; the timer does not run here.
- LAUNCH:
  - new_trans_o=1 for exactly one cycle; timer cleared; go to XFER.
  - Latency from start_i to new_trans_o is 2 cycles when the FIFO is ready.
- XFER:
  - Timer increments each cycle.
  - On dat_done_i with dat_crc_err_i=1: go to ERR, code 2.
  - On dat_done_i with dat_crc_err_i=0: decrement blocks_left_o. Go to DONE if the new value is 0, otherwise to WAIT_FIFO.
  - If the timer reaches TIMEOUT_CYCLES-1 without dat_done_i: go to ERR, code 1.
- Priority within one cycle: abort > CRC error > dat_done > timeout.
- abort_i=1 in any non-IDLE state: go to ERR, code 3 next cycle. blocks_left_o freezes; new_trans_o is never issued in that cycle.
- DONE: done_o=1 for one cycle, then IDLE.
- ERR: error_o=1 and err_code_o set, then IDLE. error_o stays high in IDLE.
- dat_done_i outside XFER is ignored.
- start_i while busy is ignored; latched values stay unchanged.
- blocks_left_o never wraps below 0.
- Reset asserted mid-transfer: immediate return to IDLE; no done_o.

Optional Feature:
- Macro SD_DAT_AUTO_STOP_EN.
- Defined: adds output stop_req_o, 1 bit, a one-cycle pulse issued with done_o when the latched block count was > 1. It requests CMD12 from the CMD block. stop_req_o is also pulsed on abort if any block was launched.
- Undefined: port absent; no stop request generated.

Decomposition:
- Shared package/include sd_dat_pkg holds:
  - state encoding (3 bits);
  - err code constants ERR_NONE, ERR_TIMEOUT, ERR_CRC, ERR_ABORT;
  - default BLK_W and TIMEOUT_CYCLES.
- One sub-module, sd_dat_timeout_timer: clear/enable inputs, expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write, 3 blocks, FIFO non-empty, dat_done_i 20 cycles after each new_trans_o -> three new_trans_o pulses; blocks_left_o 3→2→1→0; done_o one cycle; error_o=0.
- Read, 2 blocks, fifo_full_i held 1 for 50 cycles after start -> no new_trans_o until fifo_full_i drops; then normal completion.
- block_amount_i=0 -> done_o 2 cycles after start; no new_trans_o; busy_o high for 1 cycle.
- 4 blocks, CRC error on block 2 -> ERR; err_code_o=2; blocks_left_o=3; error_o sticky until the next start_i, which clears it.
- dat_done_i withheld with TIMEOUT_CYCLES=64 -> err_code_o=1 after 64 XFER cycles. abort_i and dat_done_i in the same cycle -> err_code_o=3.
- With SD_DAT_AUTO_STOP_EN: 8-block write -> stop_req_o coincident with done_o. 1-block write -> stop_req_o stays 0.
